// File: rtl/multicycle_ctrl_if.sv
// Bundle of control-sequencer signals shared between the sequencer (master)
// and the datapath / memories it drives (slave).
interface multicycle_ctrl_if;
    logic        start;
    logic [31:0] instr;
    logic [2:0]  alu_flags;
    logic        imem_en;
    logic [31:0] ir;
    logic [2:0]  flags;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_we;
    logic [1:0]  w_select;
    logic        mem_to_reg;
    logic        jal;
    logic        j_select;
    logic        jmp_reg;
    logic        jmp_instr;
    logic [2:0]  jmp_type;
    logic [1:0]  flag_select;
    logic        pc_we;
    logic        halted;
    logic [2:0]  state;

    modport master (
        input  start, instr, alu_flags,
        output imem_en, ir, flags, alu_op, alu_src, mem_rd, mem_wr, reg_we,
               w_select, mem_to_reg, jal, j_select, jmp_reg, jmp_instr,
               jmp_type, flag_select, pc_we, halted, state
    );

    modport slave (
        output start, instr, alu_flags,
        input  imem_en, ir, flags, alu_op, alu_src, mem_rd, mem_wr, reg_we,
               w_select, mem_to_reg, jal, j_select, jmp_reg, jmp_instr,
               jmp_type, flag_select, pc_we, halted, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer: owns the instruction and
// flags registers and emits Moore-style datapath selects from state and ir.
module multicycle_ctrl (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef struct packed {
        logic       imem_en;
        logic [3:0] alu_op;
        logic       alu_src;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_we;
        logic [1:0] w_select;
        logic       mem_to_reg;
        logic       jal;
        logic       j_select;
        logic       jmp_reg;
        logic       jmp_instr;
        logic [2:0] jmp_type;
        logic [1:0] flag_select;
        logic       pc_we;
        logic       halted;
    } ctrl_t;

    state_t      state_q, state_d;
    logic [31:0] ir_q;
    logic [2:0]  flags_q;
    ctrl_t       ctl;

    logic [5:0] op;
    logic [2:0] cls;
    logic       is_alu, is_mem, is_load, is_branch;

    assign op        = ir_q[31:26];
    assign cls       = op[5:3];
    assign is_alu    = (cls == 3'b000) || (cls == 3'b001);
    assign is_mem    = (cls == 3'b010);
    assign is_load   = is_mem && !op[0];
    assign is_branch = (cls == 3'b011);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                ir_q <= bus.instr;
            if (state_q == S_EXEC && is_alu)
                flags_q <= bus.alu_flags;
        end
    end

    // NOTE: every always_comb target gets a default first so no path leaves it
    // unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            // ir is not loaded yet, so the halt decision looks at the BRAM data
            S_DECODE: state_d = (bus.instr[31:26] == 6'b111111) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (is_alu)      state_d = S_WB;
                else if (is_mem) state_d = S_MEM;
                else             state_d = S_FETCH;
            end
            S_MEM:    state_d = is_load ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ctl = '0;
        case (state_q)
            S_FETCH: ctl.imem_en = 1'b1;
            S_EXEC: begin
                if (cls == 3'b000) begin
                    ctl.alu_op = ir_q[3:0];
                end else if (cls == 3'b001) begin
                    ctl.alu_op  = {1'b0, op[2:0]};
                    ctl.alu_src = 1'b1;
                end else if (is_mem) begin
                    ctl.alu_src = 1'b1;
                end else if (is_branch) begin
                    ctl.jmp_instr = 1'b1;
                    ctl.pc_we     = 1'b1;
                    ctl.jmp_type  = op[2:0];
                    case (op[2:0])
                        3'b000: ctl.j_select = 1'b1;
                        3'b001: ctl.jmp_reg  = 1'b1;
                        3'b010: begin
                            ctl.j_select = 1'b1;
                            ctl.jal      = 1'b1;
                            ctl.w_select = 2'b01;
                            ctl.reg_we   = 1'b1;
                        end
                        3'b101, 3'b110: ctl.flag_select = 2'b01;
                        3'b111:         ctl.flag_select = 2'b10;
                        default:        ctl.flag_select = 2'b00;
                    endcase
                end else begin
                    ctl.pc_we = 1'b1;
                end
            end
            S_MEM: begin
                if (is_load) begin
                    ctl.mem_rd = 1'b1;
                end else begin
                    ctl.mem_wr = 1'b1;
                    ctl.pc_we  = 1'b1;
                end
            end
            S_WB: begin
                ctl.reg_we = 1'b1;
                ctl.pc_we  = 1'b1;
                if (is_load) begin
                    ctl.w_select   = 2'b10;
                    ctl.mem_to_reg = 1'b1;
                end else begin
                    ctl.w_select = 2'b11;
                end
            end
            S_HALT:  ctl.halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.state       = state_q;
    assign bus.ir          = ir_q;
    assign bus.flags       = flags_q;
    assign bus.imem_en     = ctl.imem_en;
    assign bus.alu_op      = ctl.alu_op;
    assign bus.alu_src     = ctl.alu_src;
    assign bus.mem_rd      = ctl.mem_rd;
    assign bus.mem_wr      = ctl.mem_wr;
    assign bus.reg_we      = ctl.reg_we;
    assign bus.w_select    = ctl.w_select;
    assign bus.mem_to_reg  = ctl.mem_to_reg;
    assign bus.jal         = ctl.jal;
    assign bus.j_select    = ctl.j_select;
    assign bus.jmp_reg     = ctl.jmp_reg;
    assign bus.jmp_instr   = ctl.jmp_instr;
    assign bus.jmp_type    = ctl.jmp_type;
    assign bus.flag_select = ctl.flag_select;
    assign bus.pc_we       = ctl.pc_we;
    assign bus.halted      = ctl.halted;
endmodule
